// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: pixel strobe, scan coordinates, sync pins,
// blanking flag and end-of-frame strobe.
interface vga_sync_gen_if;
    logic       pixelTick;
    logic [9:0] pixelX;
    logic [9:0] pixelY;
    logic       hsync;
    logic       vsync;
    logic       videoOn;
    logic       frameTick;

    // Timing generator drives everything
    modport master (
        output pixelTick, pixelX, pixelY, hsync, vsync, videoOn, frameTick
    );

    // Drawing blocks, colour mux and game logic only observe
    modport slave (
        input  pixelTick, pixelX, pixelY, hsync, vsync, videoOn, frameTick
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divides the system clock to the pixel rate,
// runs horizontal/vertical scan counters and produces registered sync and
// blanking outputs aligned with the coordinates.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clock,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             von_q, von_d;
    logic             tick;
    logic             line_end;

    // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so tick is constant high
    assign tick     = (div_q == DIV_LAST);
    assign line_end = tick && (x_q == H_LAST);

    // Next-state counters (compare-and-wrap) and outputs derived from them,
    // so the registered sync/blank flags line up with the new coordinates
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);

        x_d = x_q;
        if (tick) x_d = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;

        y_d = y_q;
        if (line_end) y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;

        hs_d  = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vs_d  = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        von_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    // State registers; reset lands on pixel (0,0), which is visible and unsynced
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            x_q   <= 10'd0;
            y_q   <= 10'd0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            von_q <= 1'b1;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
        end
    end

    assign vga.pixelTick = tick;
    assign vga.pixelX    = x_q;
    assign vga.pixelY    = y_q;
    assign vga.hsync     = hs_q;
    assign vga.vsync     = vs_q;
    assign vga.videoOn   = von_q;
    assign vga.frameTick = line_end && (y_q == V_LAST);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three builds (full VGA /4, shrunken raster /4,
// shrunken raster /1) compared every cycle against a model that derives the
// whole raster state from the number of clocks since reset release.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;     // clocks since reset release
    bit phase1 = 1'b1; // window counters only valid before random resets

    vga_sync_gen_if if0 ();
    vga_sync_gen_if if1 ();
    vga_sync_gen_if if2 ();

    vga_sync_gen u0 (.clock(clk), .reset(rst), .vga(if0));
    vga_sync_gen #(.CLK_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1))
        u1 (.clock(clk), .reset(rst), .vga(if1));
    vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1))
        u2 (.clock(clk), .reset(rst), .vga(if2));

    // packed as {tick, x, y, hsync, vsync, videoOn, frameTick}
    function automatic logic [24:0] model(int tt, int d, int hd, int hf, int hs, int hb,
                                          int vd, int vf, int vs, int vb);
        int ht, vt, p, x, y;
        logic tk, h, v, von, ft;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        p   = tt / d;
        x   = p % ht;
        y   = (p / ht) % vt;
        tk  = ((tt % d) == d - 1);
        h   = !(x >= hd + hf && x < hd + hf + hs);
        v   = !(y >= vd + vf && y < vd + vf + vs);
        von = (x < hd) && (y < vd);
        ft  = tk && (x == ht - 1) && (y == vt - 1);
        return {tk, 10'(x), 10'(y), h, v, von, ft};
    endfunction

    task automatic cmp(string nm, logic [24:0] act, logic [24:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got tick=%b x=%0d y=%0d hs=%b vs=%b von=%b ft=%b want tick=%b x=%0d y=%0d hs=%b vs=%b von=%b ft=%b",
                     nm, t, act[24], act[23:14], act[13:4], act[3], act[2], act[1], act[0],
                     exp[24], exp[23:14], exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic lit(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, act, exp);
        end
    endtask

    task automatic wait_t(int n);
        int guard;
        guard = 0;
        while (t != n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (t != n) begin
            total++;
            bad++;
            $display("FAIL wait_t timeout got=%0d want=%0d", t, n);
        end
    endtask

    // clock counter that restarts on every reset
    always @(posedge clk or posedge rst) begin
        if (rst) t <= 0;
        else     t <= t + 1;
    end

    int hlo0 = 0, vlo1 = 0, ft1 = 0, vlo2 = 0, ft2 = 0;

    // every-cycle comparison against the model, plus per-window pulse counts
    always @(negedge clk) begin
        cmp("u0", {if0.pixelTick, if0.pixelX, if0.pixelY, if0.hsync, if0.vsync, if0.videoOn, if0.frameTick},
            model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        cmp("u1", {if1.pixelTick, if1.pixelX, if1.pixelY, if1.hsync, if1.vsync, if1.videoOn, if1.frameTick},
            model(t, 4, 8, 2, 3, 2, 6, 2, 2, 1));
        cmp("u2", {if2.pixelTick, if2.pixelX, if2.pixelY, if2.hsync, if2.vsync, if2.videoOn, if2.frameTick},
            model(t, 1, 8, 2, 3, 2, 6, 2, 2, 1));
        if (phase1 && !rst) begin
            if (t >= 3200 && t < 6400 && !if0.hsync) hlo0++;
            if (t >= 660 && t < 1320) begin
                if (!if1.vsync)   vlo1++;
                if (if1.frameTick) ft1++;
            end
            if (t >= 165 && t < 330) begin
                if (!if2.vsync)   vlo2++;
                if (if2.frameTick) ft2++;
            end
        end
    end

    task automatic reset_vals();
        lit("rst_x0", int'(if0.pixelX), 0);
        lit("rst_y0", int'(if0.pixelY), 0);
        lit("rst_hs0", int'(if0.hsync), 1);
        lit("rst_vs0", int'(if0.vsync), 1);
        lit("rst_von0", int'(if0.videoOn), 1);
        lit("rst_tick0", int'(if0.pixelTick), 0);
        lit("rst_ft0", int'(if0.frameTick), 0);
        lit("rst_x1", int'(if1.pixelX), 0);
        lit("rst_y1", int'(if1.pixelY), 0);
        lit("rst_tick2", int'(if2.pixelTick), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_vals();
        #2 rst = 1'b0;

        wait_t(2);    lit("tick_c2", int'(if0.pixelTick), 0);
        wait_t(3);    lit("tick_c3", int'(if0.pixelTick), 1);
        wait_t(4);    lit("x_c4", int'(if0.pixelX), 1);
        wait_t(8);    lit("x_c8", int'(if0.pixelX), 2);
        wait_t(15);   lit("u2_x_wrap", int'(if2.pixelX), 0);
                      lit("u2_y_inc", int'(if2.pixelY), 1);
        wait_t(32);   lit("u1_von_x8y0", int'(if1.videoOn), 0);
        wait_t(164);  lit("u2_ft", int'(if2.frameTick), 1);
        wait_t(328);  lit("u1_von_x7y5", int'(if1.videoOn), 1);
        wait_t(360);  lit("u1_von_x0y6", int'(if1.videoOn), 0);
        wait_t(659);  lit("u1_ft_last", int'(if1.frameTick), 1);
        wait_t(660);  lit("u1_x_frame", int'(if1.pixelX), 0);
                      lit("u1_y_frame", int'(if1.pixelY), 0);
                      lit("u1_von_frame", int'(if1.videoOn), 1);
        wait_t(2623); lit("hs_655", int'(if0.hsync), 1);
        wait_t(2624); lit("hs_656", int'(if0.hsync), 0);
        wait_t(3007); lit("hs_751", int'(if0.hsync), 0);
        wait_t(3008); lit("hs_752", int'(if0.hsync), 1);
        wait_t(3199); lit("x_799", int'(if0.pixelX), 799);
                      lit("y_0", int'(if0.pixelY), 0);
        wait_t(3200); lit("x_wrap", int'(if0.pixelX), 0);
                      lit("y_inc", int'(if0.pixelY), 1);
        wait_t(6400);
        phase1 = 1'b0;
        lit("hsync_low_clocks", hlo0, 384);
        lit("u1_vsync_low_clocks", vlo1, 120);
        lit("u1_frame_ticks", ft1, 1);
        lit("u2_vsync_low_clocks", vlo2, 30);
        lit("u2_frame_ticks", ft2, 1);

        // asynchronous resets at random points, mid-divider
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(100, 1500)) @(negedge clk);
            #($urandom_range(1, 3)) rst = 1'b1;
            #1 reset_vals();
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #2 rst = 1'b0;
        end
        repeat (800) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480 @ 60 Hz VGA display. Divides the system clock down to the pixel rate and runs horizontal/vertical scan counters. Drives the monitor's hsync/vsync pins and supplies the pixelX/pixelY coordinates and blanking flag consumed by all object-drawing blocks (ball, paddle, bricks) and the colour mux. Also emits a one-cycle end-of-frame strobe for game-logic updates.

## Interface
Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 1
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports (one clock; reset is asynchronous and active-high):
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- pixelTick  output  1  one-clock pulse per pixel period
- pixelX  output  10  horizontal count, 0..H_TOTAL-1 (799)
- pixelY  output  10  vertical count, 0..V_TOTAL-1 (524)
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- videoOn  output  1  high when pixelX < H_DISPLAY and pixelY < V_DISPLAY
- frameTick  output  1  one-clock pulse on the last pixel of the frame

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Divider: counter modulo CLK_DIV; pixelTick = (divider == CLK_DIV-1), combinational from the register. CLK_DIV=1 gives pixelTick permanently high.
- Horizontal counter: advances only on clocks where pixelTick is high; at H_TOTAL-1 wraps to 0.
- Vertical counter: advances only when pixelTick high and pixelX == H_TOTAL-1; at V_TOTAL-1 wraps to 0.
- pixelX/pixelY change only on pixelTick edges; held stable for CLK_DIV clocks.
- hsync low for pixelX in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656,751].
- vsync low for pixelY in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490,491].
- hsync, vsync, videoOn are registered, computed from next-state counter values, so they are cycle-aligned with pixelX/pixelY (no skew).
- frameTick = pixelTick && pixelX == H_TOTAL-1 && pixelY == V_TOTAL-1; exactly one clock per frame.
- All counter arithmetic 10-bit unsigned; compare-and-wrap, never natural overflow.

## Timing
- Reset values: divider 0, pixelX 0, pixelY 0, hsync 1, vsync 1, videoOn 1, pixelTick 0 (1 if CLK_DIV=1), frameTick 0.
- Reset asserted mid-frame: all outputs take reset values immediately (asynchronous); first pixelTick occurs CLK_DIV clocks after reset release.
- Line period H_TOTAL*CLK_DIV = 3200 clocks; frame period H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clocks.
- Latency: pixelX changes on the clock edge after pixelTick high; sync/videoOn change on that same edge.
- Simultaneous horizontal and vertical wrap at (799,524): both counters go to 0 on the same edge, frameTick high on the preceding clock.

## Test plan
- Reset release, CLK_DIV=4 -> pixelTick high on clocks 3,7,11,...; pixelX = 1 after clock 4, 2 after clock 8.
- Run 3200 clocks -> pixelX wraps 799->0 and pixelY 0->1 on same edge; hsync low exactly 384 clocks (pixelX 656..751) per line.
- Run full frame -> vsync low exactly 2 lines (6400 clocks) at pixelY 490..491; frameTick exactly one pulse, at (799,524); next frame starts at (0,0) after 1,680,000 clocks.
- videoOn check -> high at (639,479), low at (640,0), low at (0,480), high again at (0,0).
- Assert reset at pixel (300,200) mid-divider -> outputs return to reset values without a clock edge; timing restarts cleanly from (0,0).
- CLK_DIV=1 build -> pixelTick constant high, line period 800 clocks, frame 420,000 clocks.
